cache_wb: RTL and testbench

Parametrised direct-mapped, write-back, write-allocate cache between the pipeline memory stage and the block-wide memory model. Successor to the 4-line write-through cache: number of sets and block size are parametrised, dirty lines are evicted by an explicit FSM, and it reports a write-back counter. Processor side is a held request/readyC handshake. Memory side is a held readM/writeM request ended by a one-cycle input_readyM/doneM pulse.

---
 rtl/cache_wb.sv | 269 ++++++++++++++++++++++++++
 tb/tb_cache_wb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_wb.sv
// cache_wb: direct-mapped write-back/write-allocate cache; hit 1 cycle, clean miss 1+mem+2 cycles.
// Requests held until readyC; memory requests held until pulse; CACHE_FLUSH_EN adds a flush engine.
module cache_wb #(
    parameter int WORD_SIZE   = 16,
    parameter int NUM_SETS    = 4,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             readC,
    input  logic                             writeC,
    input  logic [WORD_SIZE-1:0]             address,
    input  logic [WORD_SIZE-1:0]             data_w,
    output logic [WORD_SIZE-1:0]             data_r,
    output logic                             readyC,
    output logic                             readM,
    output logic                             writeM,
    output logic [WORD_SIZE-1:0]             addressM,
    output logic [BLOCK_WORDS*WORD_SIZE-1:0] dataM_out,
    input  logic [BLOCK_WORDS*WORD_SIZE-1:0] dataM_in,
    input  logic                             input_readyM,
    input  logic                             doneM,
    output logic [WORD_SIZE-1:0]             num_cache_access,
    output logic [WORD_SIZE-1:0]             num_cache_miss,
    output logic [WORD_SIZE-1:0]             num_writeback
`ifdef CACHE_FLUSH_EN
    ,
    input  logic                             flush,
    output logic                             flush_done
`endif
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;
    localparam logic [WORD_SIZE-1:0] CNT_ONE = 1;

    typedef logic [BLOCK_WORDS-1:0][WORD_SIZE-1:0] line_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESP,
        S_WB,
        S_FILL
`ifdef CACHE_FLUSH_EN
        ,
        S_FLUSH
`endif
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    line_t               r_data [NUM_SETS];

    logic [WORD_SIZE-1:0]             r_data_r;
    logic                             r_readyC;
    logic                             r_readM;
    logic                             r_writeM;
    logic [WORD_SIZE-1:0]             r_addressM;
    logic [BLOCK_WORDS*WORD_SIZE-1:0] r_dataM_out;
    logic [WORD_SIZE-1:0]             r_num_access;
    logic [WORD_SIZE-1:0]             r_num_miss;
    logic [WORD_SIZE-1:0]             r_num_wb;

    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_req;
    logic             w_hit;
    logic             w_victim_dirty;
    logic [IDX_W-1:0] w_wb_idx;

    assign w_off          = address[OFF_W-1:0];
    assign w_idx          = address[OFF_W +: IDX_W];
    assign w_tag          = address[WORD_SIZE-1 -: TAG_W];
    assign w_req          = readC | writeC;
    assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];

`ifdef CACHE_FLUSH_EN
    localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;

    logic             r_flushing;
    logic [IDX_W-1:0] r_fidx;
    logic             r_flush_done;
    logic             w_flush_dirty;

    assign w_flush_dirty = r_valid[r_fidx] && r_dirty[r_fidx];
    // WB is shared: during a flush the victim is the scanned line, not the request's line
    assign w_wb_idx      = r_flushing ? r_fidx : w_idx;
    assign flush_done    = r_flush_done;
`else
    assign w_wb_idx      = w_idx;
`endif

    assign data_r           = r_data_r;
    assign readyC           = r_readyC;
    assign readM            = r_readM;
    assign writeM           = r_writeM;
    assign addressM         = r_addressM;
    assign dataM_out        = r_dataM_out;
    assign num_cache_access = r_num_access;
    assign num_cache_miss   = r_num_miss;
    assign num_writeback    = r_num_wb;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        w_next_state = S_RESP;
                    end else if (w_victim_dirty) begin
                        w_next_state = S_WB;
                    end else begin
                        w_next_state = S_FILL;
                    end
                end
`ifdef CACHE_FLUSH_EN
                else if (flush) begin
                    w_next_state = S_FLUSH;
                end
`endif
            end
            S_RESP: w_next_state = S_IDLE;
            S_WB: begin
                if (doneM) begin
`ifdef CACHE_FLUSH_EN
                    w_next_state = r_flushing ? S_FLUSH : S_FILL;
`else
                    w_next_state = S_FILL;
`endif
                end
            end
            S_FILL: begin
                if (input_readyM) begin
                    w_next_state = S_IDLE;
                end
            end
`ifdef CACHE_FLUSH_EN
            S_FLUSH: begin
                if (w_flush_dirty) begin
                    w_next_state = S_WB;
                end else if (r_fidx == IDX_LAST) begin
                    w_next_state = S_IDLE;
                end
            end
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= '0;
            r_dirty      <= '0;
            for (int i = 0; i < NUM_SETS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
            r_data_r     <= '0;
            r_readyC     <= 1'b0;
            r_readM      <= 1'b0;
            r_writeM     <= 1'b0;
            r_addressM   <= '0;
            r_dataM_out  <= '0;
            r_num_access <= '0;
            r_num_miss   <= '0;
            r_num_wb     <= '0;
`ifdef CACHE_FLUSH_EN
            r_flushing   <= 1'b0;
            r_fidx       <= '0;
            r_flush_done <= 1'b0;
`endif
        end else begin
            r_readyC <= 1'b0;
`ifdef CACHE_FLUSH_EN
            r_flush_done <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (readC) begin
                                r_data_r <= r_data[w_idx][w_off];
                            end else begin
                                r_data[w_idx][w_off] <= data_w;
                                r_dirty[w_idx]       <= 1'b1;
                            end
                            r_readyC     <= 1'b1;
                            r_num_access <= r_num_access + CNT_ONE;
                        end else begin
                            r_num_miss <= r_num_miss + CNT_ONE;
                            if (w_victim_dirty) begin
                                r_writeM    <= 1'b1;
                                r_addressM  <= {r_tag[w_idx], w_idx, {OFF_W{1'b0}}};
                                r_dataM_out <= r_data[w_idx];
                            end else begin
                                r_readM    <= 1'b1;
                                r_addressM <= {w_tag, w_idx, {OFF_W{1'b0}}};
                            end
                        end
                    end
`ifdef CACHE_FLUSH_EN
                    else if (flush) begin
                        r_flushing <= 1'b1;
                        r_fidx     <= '0;
                    end
`endif
                end
                S_WB: begin
                    if (doneM) begin
                        r_writeM          <= 1'b0;
                        r_dirty[w_wb_idx] <= 1'b0;
                        r_num_wb          <= r_num_wb + CNT_ONE;
`ifdef CACHE_FLUSH_EN
                        if (!r_flushing) begin
                            r_readM    <= 1'b1;
                            r_addressM <= {w_tag, w_idx, {OFF_W{1'b0}}};
                        end
`else
                        r_readM    <= 1'b1;
                        r_addressM <= {w_tag, w_idx, {OFF_W{1'b0}}};
`endif
                    end
                end
                S_FILL: begin
                    if (input_readyM) begin
                        r_data[w_idx]  <= dataM_in;
                        r_tag[w_idx]   <= w_tag;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_readM        <= 1'b0;
                    end
                end
`ifdef CACHE_FLUSH_EN
                S_FLUSH: begin
                    // a written-back line comes back here clean, so it advances on the next pass
                    if (w_flush_dirty) begin
                        r_writeM    <= 1'b1;
                        r_addressM  <= {r_tag[r_fidx], r_fidx, {OFF_W{1'b0}}};
                        r_dataM_out <= r_data[r_fidx];
                    end else if (r_fidx == IDX_LAST) begin
                        r_flushing   <= 1'b0;
                        r_flush_done <= 1'b1;
                    end else begin
                        r_fidx <= r_fidx + IDX_ONE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_wb.sv
// Randomized bench for cache_wb: flat coherent-memory reference plus a tag-array model for hit/miss/eviction.
module tb_cache_wb;

    localparam int WS = 16;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          readC = 1'b0, writeC = 1'b0;
    logic [WS-1:0] address = '0, data_w = '0;
    logic [WS-1:0] data_r;
    logic          readyC, readM, writeM;
    logic [WS-1:0] addressM;
    logic [BW*WS-1:0] dataM_out;
    logic [BW*WS-1:0] dataM_in = '0;
    logic          input_readyM = 1'b0, doneM = 1'b0;
    logic [WS-1:0] num_cache_access, num_cache_miss, num_writeback;
`ifdef CACHE_FLUSH_EN
    logic          flush = 1'b0;
    logic          flush_done;
`endif

    cache_wb dut (
        .clk(clk), .reset(reset), .readC(readC), .writeC(writeC),
        .address(address), .data_w(data_w), .data_r(data_r), .readyC(readyC),
        .readM(readM), .writeM(writeM), .addressM(addressM), .dataM_out(dataM_out),
        .dataM_in(dataM_in), .input_readyM(input_readyM), .doneM(doneM),
        .num_cache_access(num_cache_access), .num_cache_miss(num_cache_miss),
        .num_writeback(num_writeback)
`ifdef CACHE_FLUSH_EN
        , .flush(flush), .flush_done(flush_done)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit            w;
        logic [WS-1:0] a;
        logic [63:0]   d;
    } mop_t;
    mop_t mop_q[$];

    logic [WS-1:0]    ref_mem [int];
    logic [BW*WS-1:0] mem_blk [int];
    bit               mem_hold = 1'b0;

    function automatic logic [WS-1:0] init_word(input int a);
        return WS'((a * 16'h0123) ^ 16'h5AC3);
    endfunction

    function automatic logic [WS-1:0] get_ref(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [63:0] ref_line(input int base);
        logic [63:0] l;
        for (int w = 0; w < BW; w++) l[w*WS +: WS] = get_ref(base + w);
        return l;
    endfunction

    function automatic logic [63:0] backing_line(input int base);
        logic [63:0] l;
        if (mem_blk.exists(base)) return mem_blk[base];
        for (int w = 0; w < BW; w++) l[w*WS +: WS] = init_word(base + w);
        return l;
    endfunction

    // memory responder: random latency, abandons a request that drops (reset)
    initial begin
        int   n, k;
        bit   is_w;
        mop_t m;
        forever begin
            @(negedge clk);
            if ((readM || writeM) && !reset) begin
                is_w = writeM;
                m.w = is_w; m.a = addressM; m.d = dataM_out;
                n = $urandom_range(0, 3);
                k = 0;
                while ((k < n || mem_hold) && (is_w ? writeM : readM)) begin
                    @(negedge clk);
                    k++;
                end
                if (is_w ? writeM : readM) begin
                    mop_q.push_back(m);
                    if (is_w) begin
                        mem_blk[int'(m.a)] = m.d;
                        doneM = 1'b1;
                    end else begin
                        dataM_in = backing_line(int'(m.a));
                        input_readyM = 1'b1;
                    end
                    @(negedge clk);
                    doneM = 1'b0;
                    input_readyM = 1'b0;
                end
            end
        end
    end

    bit m_valid [4];
    bit m_dirty [4];
    int m_tag   [4];
    int e_acc = 0, e_miss = 0, e_wb = 0;

    task automatic access(input bit wr, input logic [WS-1:0] a, input logic [WS-1:0] wd);
        int idx, tg, vaddr, lat, nops;
        bit hit, wbx, seen;
        idx   = (int'(a) >> 2) & 3;
        tg    = int'(a) >> 4;
        hit   = m_valid[idx] && (m_tag[idx] == tg);
        wbx   = !hit && m_valid[idx] && m_dirty[idx];
        vaddr = (m_tag[idx] << 4) | (idx << 2);
        if (!hit) e_miss++;
        if (wbx) e_wb++;
        e_acc++;
        mop_q.delete();
        @(negedge clk);
        readC = !wr; writeC = wr; address = a; data_w = wd;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            seen = readyC;
        end
        check_eq("readyC_seen", 64'(seen), 64'd1);
        if (!wr) check_eq("data_r", 64'(data_r), 64'(get_ref(int'(a))));
        readC = 1'b0; writeC = 1'b0;
        nops = mop_q.size();
        if (hit) begin
            check_eq("hit_latency", 64'(lat), 64'd1);
            check_eq("hit_mem_ops", 64'(nops), 64'd0);
        end else begin
            check_eq("miss_mem_ops", 64'(nops), wbx ? 64'd2 : 64'd1);
            if (nops == (wbx ? 2 : 1)) begin
                if (wbx) begin
                    check_eq("wb_is_write", 64'(mop_q[0].w), 64'd1);
                    check_eq("wb_addr", 64'(mop_q[0].a), 64'(vaddr));
                    check_eq("wb_data", mop_q[0].d, ref_line(vaddr));
                end
                check_eq("fill_is_read", 64'(mop_q[nops-1].w), 64'd0);
                check_eq("fill_addr", 64'(mop_q[nops-1].a), 64'(int'(a) & ~3));
            end
        end
        check_eq("num_access", 64'(num_cache_access), 64'(e_acc));
        check_eq("num_miss", 64'(num_cache_miss), 64'(e_miss));
        check_eq("num_writeback", 64'(num_writeback), 64'(e_wb));
        m_dirty[idx] = hit ? (m_dirty[idx] | wr) : wr;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        if (wr) ref_mem[int'(a)] = wd;
    endtask

`ifdef CACHE_FLUSH_EN
    task automatic do_flush();
        int exp_idx[$];
        int lat;
        bit seen;
        for (int i = 0; i < 4; i++) if (m_valid[i] && m_dirty[i]) exp_idx.push_back(i);
        mop_q.delete();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        lat = 0; seen = flush_done;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            seen = flush_done;
        end
        check_eq("flush_done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        check_eq("flush_done_pulse", 64'(flush_done), 64'd0);
        check_eq("flush_ops", 64'(mop_q.size()), 64'(exp_idx.size()));
        if (mop_q.size() == exp_idx.size()) begin
            foreach (exp_idx[j]) begin
                check_eq("flush_is_write", 64'(mop_q[j].w), 64'd1);
                check_eq("flush_addr", 64'(mop_q[j].a), 64'((m_tag[exp_idx[j]] << 4) | (exp_idx[j] << 2)));
                check_eq("flush_data", mop_q[j].d, ref_line(int'(mop_q[j].a)));
            end
        end
        e_wb += exp_idx.size();
        for (int i = 0; i < 4; i++) m_dirty[i] = 1'b0;
        check_eq("flush_num_wb", 64'(num_writeback), 64'(e_wb));
    endtask
`endif

    initial begin
        int seen;
        mem_blk[16'h0010] = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        ref_mem[16'h10] = 16'hAAAA; ref_mem[16'h11] = 16'hBBBB;
        ref_mem[16'h12] = 16'hCCCC; ref_mem[16'h13] = 16'hDDDD;
        for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; end

        repeat (3) @(negedge clk);
        check_eq("rst_readyC", 64'(readyC), 64'd0);
        check_eq("rst_readM", 64'(readM), 64'd0);
        check_eq("rst_writeM", 64'(writeM), 64'd0);
        check_eq("rst_data_r", 64'(data_r), 64'd0);
        check_eq("rst_addressM", 64'(addressM), 64'd0);
        check_eq("rst_counters", 64'({num_cache_access, num_cache_miss, num_writeback}), 64'd0);
        reset = 1'b0;

        access(0, 16'h0013, 16'h0);
        check_eq("first_read_data", 64'(data_r), 64'hDDDD);
        access(0, 16'h0011, 16'h0);
        check_eq("second_read_data", 64'(data_r), 64'hBBBB);
        access(1, 16'h0012, 16'h1234);
        access(0, 16'h0012, 16'h0);
        check_eq("readback_1234", 64'(data_r), 64'h1234);
        access(0, 16'h0053, 16'h0);
        if (mop_q.size() == 2) check_eq("wb_word2", 64'(mop_q[0].d[47:32]), 64'h1234);
        check_eq("wb_count_1", 64'(num_writeback), 64'd1);

        // reset while a fill is outstanding
        mem_hold = 1'b1;
        @(negedge clk);
        readC = 1'b1; address = 16'h0013;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = int'(readM);
        end
        check_eq("hold_fill_seen", 64'(seen), 64'd1);
        reset = 1'b1; readC = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_readM", 64'(readM), 64'd0);
        check_eq("rst_mid_counters", 64'({num_cache_access, num_cache_miss, num_writeback}), 64'd0);
        reset = 1'b0; mem_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
        e_acc = 0; e_miss = 0; e_wb = 0;
        access(0, 16'h0013, 16'h0);
        check_eq("post_rst_miss", 64'(num_cache_miss), 64'd1);

        for (int n = 0; n < 200; n++) begin
            access(($urandom_range(0, 9) < 4), WS'($urandom_range(0, 63)), WS'($urandom));
        end

`ifdef CACHE_FLUSH_EN
        do_flush();
        access(1, 16'h0104, 16'hBEEF);
        access(1, 16'h010C, 16'hCAFE);
        do_flush();
        access(0, 16'h0104, 16'h0);
        access(0, 16'h010C, 16'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
